pic_scanout: RTL and testbench
==============================

# pic_scanout

Pixel-clock reader for the 2048×8 picture RAM. The CPU writes the RAM on the system clock. This block runs entirely in the `vga_clk` domain. It generates 640×480 VGA timing, fetches bytes from the RAM read port as a 128×128 monochrome bitmap, and serialises them into a 1-bit pixel stream. Its sync and data-enable outputs are pipeline-aligned with that stream.

## Interface
Parameters:
- `H_ACTIVE` 640, `H_FP` 16, `H_SYNC` 96, `H_BP` 48: horizontal timing in pixels.
- `V_ACTIVE` 480, `V_FP` 10, `V_SYNC` 2, `V_BP` 33: vertical timing in lines.
- `PIC_X` 256, `PIC_Y` 176: top-left corner of the 128×128 bitmap window.
- `SYNC_NEG` 1: 1 means sync pulses are active-low.

Ports:
- `vga_clk` in 1: pixel clock; the only clock in this block.
- `reset` in 1: asynchronous, active-high.
- `picaddr` out 11: RAM read address, registered.
- `glyph` in 8: RAM read data, valid one `vga_clk` after `picaddr` is sampled.
- `hsync` out 1: horizontal sync, polarity set by `SYNC_NEG`.
- `vsync` out 1: vertical sync, polarity set by `SYNC_NEG`.
- `de` out 1: high during the visible 640×480 region.
- `pixel` out 1: bitmap bit; 0 outside the window or outside the visible region.
- `frame_start` out 1: one-cycle pulse, coincident with the output for pixel (0,0).

## Operation
- **Counters**
  - `hcnt` counts 0..H_TOTAL-1 (800), then wraps to 0; each wrap advances `vcnt`.
  - `vcnt` counts 0..V_TOTAL-1 (525), then wraps to 0.
  - Both are 10 bits wide.
- **Window**
  - In-window condition: `PIC_X ≤ hcnt < PIC_X+128` and `PIC_Y ≤ vcnt < PIC_Y+128`.
  - `wx = hcnt-PIC_X` (7 bits); `wy = vcnt-PIC_Y` (7 bits).
- **Address**
  - `picaddr = {wy[6:0], wx[6:3]}`: 16 bytes per row, row-major, one byte covers 8 horizontal pixels.
  - `picaddr` is registered from stage-0 counters.
  - Outside the window, `picaddr` holds its last value; no reads are required there.
- **Bit select**
  - `pixel = glyph[7 - wx[2:0]]`, so the MSB is the leftmost pixel.
  - `wx[2:0]` and the in-window flag are delayed to match the RAM latency.
- **Sync**
  - hsync is asserted for `H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC`.
  - vsync is asserted for the equivalent range in `vcnt`.
  - `de` = `hcnt < H_ACTIVE && vcnt < V_ACTIVE`.
- **Pipeline**
  - S0: counters.
  - S1: `picaddr` register, plus delayed flags.
  - S2: RAM output `glyph`, plus delayed flags.
  - S3: output registers.
  - `hsync`, `vsync`, `de`, `frame_start` and `pixel` all come from S3. They are therefore mutually aligned, three cycles after the counter state that produced them.
- **No handshake**: the RAM read port is always enabled, and the block issues one address every cycle.

## Timing
- **Reset values**
  - `hcnt = 0`, `vcnt = 0`, `picaddr = 0`.
  - `hsync = vsync = SYNC_NEG` (deasserted level).
  - `de = 0`, `pixel = 0`, `frame_start = 0`.
  - All pipeline flags are cleared.
- **After reset release**
  - The first counter state (0,0) reaches the outputs on the 3rd rising edge.
  - `frame_start` pulses on that edge.
  - The output stage is fully valid from then on.
- **Reset mid-frame**: all outputs return to their reset values immediately (asynchronous). Counting restarts at (0,0). No partial-line outputs are permitted.
- **Wrap-around**
  - `hcnt` = 799 → 0 increments `vcnt` on the same edge.
  - (799, 524) → (0, 0).
  - `frame_start` fires once per 420000 cycles.
- **Window edges**
  - Column `PIC_X+127` uses `glyph` bit 0 of byte `{wy,4'hF}`.
  - Column `PIC_X+128` outputs `pixel = 0`.
  - Any change in `glyph` while the bit is not selected must not disturb `pixel`.

## Structure
- Shared package `vga_pkg` holds:
  - the timing defaults and the H_TOTAL/V_TOTAL derivation;
  - the constant `PIC_LAT = 1` (RAM read latency);
  - the constant `PIPE = 3`.
- One sub-module, `vga_timing`: the counters plus the sync/de/frame flag generation at S0.
- `pic_scanout` contains the address generation, the delay lines and the output registers.

## Test plan
- Hold reset for 5 cycles, then release. Required: all outputs at reset values during reset; `frame_start` high exactly on the 3rd edge after release; `de = 1` on the same edge.
- Run 2 frames and count:
  - `hsync` active for 96 cycles per 800;
  - `vsync` active for 2 lines (1600 cycles) per 525 lines;
  - `de` high for 307200 cycles per frame;
  - `frame_start` period of 420000 cycles.
- RAM model: 1-cycle latency, each byte set to its address[7:0]. Required:
  - at counter (256,176), `picaddr = 0`;
  - at (263,177), `picaddr = 16`;
  - the pixel stream on row 176 reproduces the bits of bytes 0x00..0x0F, MSB first.
- RAM filled with 0xFF. Required: `pixel = 1` exactly for `hcnt` 256..383 and `vcnt` 176..303, delayed by 3 cycles; `pixel = 0` at column 384 and at row 304.
- Assert reset at counter (400,200) mid-window, then release. Required: outputs go to reset values within the same cycle; the next `frame_start` arrives 3 cycles after release.
- Set `SYNC_NEG = 0`. Required: `hsync`/`vsync` reset to 0 and pulse high for the same intervals as in the second scenario.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, picture-window geometry and the per-pixel flag
// bundle that travels down the scan-out pipeline.
package vga_pkg;

  function automatic int line_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int H_TOTAL_DEF  = line_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF  = line_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  localparam int PIC_X_DEF = 256;
  localparam int PIC_Y_DEF = 176;
  localparam int PIC_DIM   = 128;

  localparam int CNT_W   = 10;
  localparam int ADDR_W  = 11;
  localparam int PIC_LAT = 1;
  localparam int PIPE    = 3;

  // Active-high per-pixel attributes; sync polarity is applied only at the output.
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       frame;
    logic       win;
    logic [2:0] bit_sel;
  } flags_t;

endpackage

// File: rtl/vga_timing.sv
// Stage-0 raster counters and the active-high sync/de/frame flags they imply.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             vga_clk,
  input  logic             reset,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic             frame
);

  localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the always blocks are evaluated.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  assign hs    = (hcnt >= HS_START) && (hcnt < HS_END);
  assign vs    = (vcnt >= VS_START) && (vcnt < VS_END);
  assign de    = (hcnt < H_VIS) && (vcnt < V_VIS);
  assign frame = (hcnt == '0) && (vcnt == '0);

endmodule

// File: rtl/pic_scanout.sv
// Scans a 128x128 monochrome bitmap out of the picture RAM as a 1-bit pixel
// stream with sync/de/frame_start aligned three clocks behind the counters.
module pic_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int PIC_X    = PIC_X_DEF,
  parameter int PIC_Y    = PIC_Y_DEF,
  parameter bit SYNC_NEG = 1'b1
) (
  input  logic              vga_clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] picaddr,
  input  logic [7:0]        glyph,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              pixel,
  output logic              frame_start
);

  localparam logic [CNT_W-1:0] WX0 = CNT_W'(PIC_X);
  localparam logic [CNT_W-1:0] WX1 = CNT_W'(PIC_X + PIC_DIM);
  localparam logic [CNT_W-1:0] WY0 = CNT_W'(PIC_Y);
  localparam logic [CNT_W-1:0] WY1 = CNT_W'(PIC_Y + PIC_DIM);

  logic [CNT_W-1:0] hcnt, vcnt;
  logic             hs0, vs0, de0, frame0;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .vga_clk(vga_clk),
    .reset  (reset),
    .hcnt   (hcnt),
    .vcnt   (vcnt),
    .hs     (hs0),
    .vs     (vs0),
    .de     (de0),
    .frame  (frame0)
  );

  logic [6:0] wx, wy;
  logic       in_win;
  flags_t     s0, s1, s2;
  flags_t     lat_q [PIC_LAT];

  assign wx     = 7'(hcnt - WX0);
  assign wy     = 7'(vcnt - WY0);
  assign in_win = (hcnt >= WX0) && (hcnt < WX1) && (vcnt >= WY0) && (vcnt < WY1);
  assign s0     = '{hs: hs0, vs: vs0, de: de0, frame: frame0, win: in_win, bit_sel: wx[2:0]};

  // S1: address register; it holds outside the window since no read is needed there.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      picaddr <= '0;
      s1      <= '0;
    end else begin
      s1 <= s0;
      if (in_win) picaddr <= {wy, wx[6:3]};
    end
  end

  // NOTE: this flag delay line is reset, unlike a data RAM, because stale
  // flags would leak a partial line onto the outputs after a mid-frame reset.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIC_LAT; i++) lat_q[i] <= '0;
    end else begin
      lat_q[0] <= s1;
      for (int i = 1; i < PIC_LAT; i++) lat_q[i] <= lat_q[i-1];
    end
  end

  assign s2 = lat_q[PIC_LAT-1];

  // S3: glyph is valid here; MSB is the leftmost pixel of each byte.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hsync       <= SYNC_NEG;
      vsync       <= SYNC_NEG;
      de          <= 1'b0;
      pixel       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= s2.hs ^ SYNC_NEG;
      vsync       <= s2.vs ^ SYNC_NEG;
      de          <= s2.de;
      pixel       <= s2.win && s2.de && glyph[3'd7 - s2.bit_sel];
      frame_start <= s2.frame;
    end
  end

endmodule

// File: tb/tb_pic_scanout.sv
// Directed bench for pic_scanout on a shrunken raster (216x142) so whole frames
// fit in a short run; a second instance exercises active-high sync polarity.
module tb_pic_scanout;

  localparam int HA = 200, HF = 4, HS = 8, HB = 4, HT = 216;
  localparam int VA = 136, VF = 2, VS = 2, VB = 2, VT = 142;
  localparam int PX = 40, PY = 4;
  localparam int FRAME = HT * VT;

  logic        vga_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        ram_ff  = 1'b0;
  logic [10:0] picaddr_n, picaddr_p;
  logic [7:0]  glyph_n, glyph_p;
  logic        hsync_n, vsync_n, de_n, pixel_n, fs_n;
  logic        hsync_p, vsync_p, de_p, pixel_p, fs_p;

  int passed = 0, total = 0;
  int cyc = 0;
  int hs_cnt_n = 0, vs_cnt_n = 0, hs_cnt_p = 0, vs_cnt_p = 0, de_cnt = 0;
  int fs_cnt1 = 0, fs_cnt2 = 0, pix_err = 0, sync_err = 0;
  logic [127:0] row_bits = '0;

  always #5 vga_clk = ~vga_clk;

  pic_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIC_X(PX), .PIC_Y(PY), .SYNC_NEG(1'b1)
  ) dut_n (
    .vga_clk(vga_clk), .reset(reset), .picaddr(picaddr_n), .glyph(glyph_n),
    .hsync(hsync_n), .vsync(vsync_n), .de(de_n), .pixel(pixel_n), .frame_start(fs_n)
  );

  pic_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIC_X(PX), .PIC_Y(PY), .SYNC_NEG(1'b0)
  ) dut_p (
    .vga_clk(vga_clk), .reset(reset), .picaddr(picaddr_p), .glyph(glyph_p),
    .hsync(hsync_p), .vsync(vsync_p), .de(de_p), .pixel(pixel_p), .frame_start(fs_p)
  );

  // One-cycle-latency RAM: byte = address[7:0], or all ones when ram_ff is set.
  always_ff @(posedge vga_clk) begin
    glyph_n <= ram_ff ? 8'hFF : picaddr_n[7:0];
    glyph_p <= ram_ff ? 8'hFF : picaddr_p[7:0];
  end

  function automatic bit in_win(input int h, input int v);
    return (h >= PX) && (h < PX + 128) && (v >= PY) && (v < PY + 128);
  endfunction

  function automatic bit pattern_pix(input int h, input int v);
    int wx, wy, byte_val;
    if (!in_win(h, v)) return 1'b0;
    wx = h - PX;
    wy = v - PY;
    byte_val = ((wy << 4) | (wx >> 3)) & 255;
    return bit'((byte_val >> (7 - (wx % 8))) & 1);
  endfunction

  task automatic step;
    @(negedge vga_clk);
    cyc++;
  endtask

  // Sample one output cycle (output index n = cyc-3) against the raster model.
  task automatic sample_cycle(input bit ff_mode);
    int  n, h, v;
    bit  hs_exp, vs_exp, de_exp, pix_exp;
    n = cyc - 3;
    h = n % HT;
    v = (n / HT) % VT;
    hs_exp  = (h >= HA + HF) && (h < HA + HF + HS);
    vs_exp  = (v >= VA + VF) && (v < VA + VF + VS);
    de_exp  = (h < HA) && (v < VA);
    pix_exp = ff_mode ? in_win(h, v) : pattern_pix(h, v);
    if (!hsync_n) hs_cnt_n++;
    if (!vsync_n) vs_cnt_n++;
    if (hsync_p)  hs_cnt_p++;
    if (vsync_p)  vs_cnt_p++;
    if (de_n)     de_cnt++;
    if (hsync_n !== !hs_exp || vsync_n !== !vs_exp || de_n !== de_exp ||
        hsync_p !== hs_exp || vsync_p !== vs_exp || de_p !== de_exp ||
        fs_n !== (n % FRAME == 0) || fs_p !== (n % FRAME == 0)) sync_err++;
    if (pixel_n !== pix_exp || pixel_p !== pix_exp) pix_err++;
  endtask

  task automatic test_reset;
    repeat (5) @(negedge vga_clk);
    total++; if (hsync_n !== 1'b1) $display("FAIL reset_hsync_n: got %b want 1", hsync_n); else passed++;
    total++; if (vsync_n !== 1'b1) $display("FAIL reset_vsync_n: got %b want 1", vsync_n); else passed++;
    total++; if (hsync_p !== 1'b0 || vsync_p !== 1'b0)
      $display("FAIL reset_sync_p: got %b%b want 00", hsync_p, vsync_p); else passed++;
    total++; if ({de_n, pixel_n, fs_n} !== 3'b000)
      $display("FAIL reset_de_pix_fs: got %b want 000", {de_n, pixel_n, fs_n}); else passed++;
    total++; if (picaddr_n !== 11'd0) $display("FAIL reset_picaddr: got %0d want 0", picaddr_n); else passed++;
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_startup;
    step;
    step;
    total++; if (fs_n !== 1'b0 || de_n !== 1'b0)
      $display("FAIL startup_early: fs=%b de=%b want 0 0", fs_n, de_n); else passed++;
    step;
    total++; if (fs_n !== 1'b1) $display("FAIL startup_fs: got %b want 1 on edge 3", fs_n); else passed++;
    total++; if (de_n !== 1'b1) $display("FAIL startup_de: got %b want 1 on edge 3", de_n); else passed++;
  endtask

  task automatic test_frame_pattern;
    logic [127:0] row_exp;
    for (int b = 0; b < 16; b++) row_exp[127 - 8*b -: 8] = 8'(b);
    for (int k = 0; k < FRAME; k++) begin
      int n, h, v;
      n = cyc - 3;
      h = n % HT;
      v = n / HT;
      sample_cycle(1'b0);
      if (fs_n) fs_cnt1++;
      if (v == PY && in_win(h, v)) row_bits[127 - (h - PX)] = pixel_n;
      if (n + 2 == PY * HT + PX) begin
        total++; if (picaddr_n !== 11'd0) $display("FAIL picaddr_origin: got %0d want 0", picaddr_n); else passed++;
      end
      if (n + 2 == (PY + 1) * HT + PX + 7) begin
        total++; if (picaddr_n !== 11'd16) $display("FAIL picaddr_row1: got %0d want 16", picaddr_n); else passed++;
      end
      if (n == (PY + 130) * HT) ram_ff = 1'b1;
      step;
    end
    total++; if (row_bits !== row_exp) $display("FAIL row0_bits: got %h want %h", row_bits, row_exp); else passed++;
    total++; if (fs_cnt1 !== 1) $display("FAIL frame1_fs_count: got %0d want 1", fs_cnt1); else passed++;
  endtask

  task automatic test_window_ff;
    total++; if (fs_n !== 1'b1) $display("FAIL fs_period: got %b want 1 after %0d cycles", fs_n, FRAME); else passed++;
    for (int k = 0; k < FRAME; k++) begin
      int n, h, v;
      n = cyc - 3 - FRAME;
      h = n % HT;
      v = n / HT;
      sample_cycle(1'b1);
      if (fs_n) fs_cnt2++;
      if (h == PX + 128 && v == PY + 10) begin
        total++; if (pixel_n !== 1'b0) $display("FAIL col_past_window: got %b want 0", pixel_n); else passed++;
      end
      if (h == PX + 127 && v == PY + 127) begin
        total++; if (pixel_n !== 1'b1) $display("FAIL last_window_pixel: got %b want 1", pixel_n); else passed++;
      end
      if (h == PX + 5 && v == PY + 128) begin
        total++; if (pixel_n !== 1'b0) $display("FAIL row_past_window: got %b want 0", pixel_n); else passed++;
      end
      if (h == PX - 1 && v == PY) begin
        total++; if (pixel_n !== 1'b0) $display("FAIL col_before_window: got %b want 0", pixel_n); else passed++;
      end
      step;
    end
    total++; if (fs_cnt2 !== 1) $display("FAIL frame2_fs_count: got %0d want 1", fs_cnt2); else passed++;
    total++; if (pix_err !== 0) $display("FAIL pixel_stream: %0d cycles differ, want 0", pix_err); else passed++;
    total++; if (sync_err !== 0) $display("FAIL sync_alignment: %0d cycles differ, want 0", sync_err); else passed++;
    total++; if (hs_cnt_n !== 2 * HS * VT) $display("FAIL hsync_count: got %0d want %0d", hs_cnt_n, 2 * HS * VT); else passed++;
    total++; if (vs_cnt_n !== 2 * VS * HT) $display("FAIL vsync_count: got %0d want %0d", vs_cnt_n, 2 * VS * HT); else passed++;
    total++; if (de_cnt !== 2 * HA * VA) $display("FAIL de_count: got %0d want %0d", de_cnt, 2 * HA * VA); else passed++;
  endtask

  task automatic test_sync_pos;
    total++; if (hs_cnt_p !== 2 * HS * VT) $display("FAIL hsync_pos_count: got %0d want %0d", hs_cnt_p, 2 * HS * VT); else passed++;
    total++; if (vs_cnt_p !== 2 * VS * HT) $display("FAIL vsync_pos_count: got %0d want %0d", vs_cnt_p, 2 * VS * HT); else passed++;
  endtask

  task automatic test_reset_mid;
    bit found = 1'b0;
    for (int k = 0; k < FRAME && !found; k++) begin
      if (cyc % FRAME == (PY + 30) * HT + PX + 100) found = 1'b1;
      else step;
    end
    total++; if (!found || pixel_n !== 1'b1)
      $display("FAIL mid_precondition: found=%b pixel=%b want 1 1", found, pixel_n); else passed++;
    reset = 1'b1;
    #1;
    total++; if ({hsync_n, vsync_n, de_n, pixel_n, fs_n} !== 5'b11000)
      $display("FAIL mid_reset_outputs: got %b want 11000", {hsync_n, vsync_n, de_n, pixel_n, fs_n}); else passed++;
    total++; if (picaddr_n !== 11'd0 || {hsync_p, vsync_p} !== 2'b00)
      $display("FAIL mid_reset_addr_sync_p: addr=%0d sync_p=%b want 0 00", picaddr_n, {hsync_p, vsync_p}); else passed++;
    step;
    step;
    reset = 1'b0;
    cyc = 0;
    step;
    step;
    total++; if (fs_n !== 1'b0 || de_n !== 1'b0 || pixel_n !== 1'b0)
      $display("FAIL mid_no_partial: fs=%b de=%b pix=%b want 0 0 0", fs_n, de_n, pixel_n); else passed++;
    step;
    total++; if (fs_n !== 1'b1 || de_n !== 1'b1)
      $display("FAIL mid_restart_fs: fs=%b de=%b want 1 1", fs_n, de_n); else passed++;
  endtask

  initial begin
    test_reset;
    test_startup;
    test_frame_pattern;
    test_window_ff;
    test_sync_pos;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
